amp_state_control: RTL and testbench

- Power-up and fault sequencer for the external class-D amplifier front end.
- Walks the amplifier through a fixed sequence: disabled, enabled, configured, muted, playing.
- Drives the active-low enable and mute pins, and pulses a request to the config sender.
- Monitors the amplifier's active-low error pin and the audio PLL lock flag; recovers automatically from faults.

---
 rtl/amp_state_control.sv | 147 ++++++++++++++
 tb/tb_amp_state_control.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/amp_state_control.sv
// amp_state_control: power-up and fault sequencer for the class-D amplifier.
// Walks DISABLED -> ENA_WAIT -> CONFIG -> CFG_WAIT -> MUTED -> PLAY and drops
// to ERROR whenever the amp reports a fault while enabled.
// Build option: define AMP_ERR_LATCH_EN to make ERROR terminal until reset
// (ERR_CYC then has no effect); by default the block restarts after ERR_CYC.
module amp_state_control #(
  parameter int unsigned PWRUP_CYC  = 10000,
  parameter int unsigned CFG_CYC    = 1000,
  parameter int unsigned UNMUTE_CYC = 256,
  parameter int unsigned ERR_CYC    = 5000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic audio_locked,
  input  logic nerror,
  output logic nenable,
  output logic nmute,
  output logic send_config
);

  typedef enum logic [2:0] {
    S_DISABLED = 3'd0,
    S_ENA_WAIT = 3'd1,
    S_CONFIG   = 3'd2,
    S_CFG_WAIT = 3'd3,
    S_MUTED    = 3'd4,
    S_PLAY     = 3'd5,
    S_ERROR    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] PWRUP_LD  = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] CFG_LD    = CNT_W'(CFG_CYC - 1);
  localparam logic [CNT_W-1:0] UNMUTE_LD = CNT_W'(UNMUTE_CYC - 1);
`ifndef AMP_ERR_LATCH_EN
  localparam logic [CNT_W-1:0] ERR_LD    = CNT_W'(ERR_CYC - 1);
`endif

  state_t           state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;

  logic lock_s1, lock_s;
  logic nerr_s1, nerr_s;
  logic lock, err;

  // Two-flop synchronizers for the asynchronous lock and error pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_s1 <= 1'b0;
      lock_s  <= 1'b0;
      nerr_s1 <= 1'b1;
      nerr_s  <= 1'b1;
    end else begin
      lock_s1 <= audio_locked;
      lock_s  <= lock_s1;
      nerr_s1 <= nerror;
      nerr_s  <= nerr_s1;
    end
  end

  assign lock = lock_s;
  assign err  = ~nerr_s;

  // Next-state and shared down-counter; a fault in any enabled state wins
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    unique case (state_q)
      S_DISABLED: begin
        state_nx = S_ENA_WAIT;
        cnt_nx   = PWRUP_LD;
      end
      S_ENA_WAIT, S_CONFIG, S_CFG_WAIT, S_MUTED, S_PLAY: begin
        if (err) begin
          state_nx = S_ERROR;
`ifdef AMP_ERR_LATCH_EN
          cnt_nx   = '0;
`else
          cnt_nx   = ERR_LD;
`endif
        end else begin
          unique case (state_q)
            S_ENA_WAIT: begin
              if (cnt_q == '0) state_nx = S_CONFIG;
              else             cnt_nx   = cnt_q - CNT_W'(1);
            end
            S_CONFIG: begin
              state_nx = S_CFG_WAIT;
              cnt_nx   = CFG_LD;
            end
            S_CFG_WAIT: begin
              if (cnt_q == '0) begin
                state_nx = S_MUTED;
                cnt_nx   = UNMUTE_LD;
              end else begin
                cnt_nx = cnt_q - CNT_W'(1);
              end
            end
            S_MUTED: begin
              if (!lock)            cnt_nx   = UNMUTE_LD;
              else if (cnt_q == '0) state_nx = S_PLAY;
              else                  cnt_nx   = cnt_q - CNT_W'(1);
            end
            default: begin
              if (!lock) begin
                state_nx = S_MUTED;
                cnt_nx   = UNMUTE_LD;
              end
            end
          endcase
        end
      end
      S_ERROR: begin
`ifdef AMP_ERR_LATCH_EN
        state_nx = S_ERROR;
        cnt_nx   = '0;
`else
        if (cnt_q == '0) state_nx = S_DISABLED;
        else             cnt_nx   = cnt_q - CNT_W'(1);
`endif
      end
      default: begin
        state_nx = S_DISABLED;
        cnt_nx   = '0;
      end
    endcase
  end

  // State, counter and outputs registered together; outputs decode the
  // next state so pins change on the same edge as the state they belong to
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_DISABLED;
      cnt_q       <= '0;
      nenable     <= 1'b1;
      nmute       <= 1'b0;
      send_config <= 1'b0;
    end else begin
      state_q     <= state_nx;
      cnt_q       <= cnt_nx;
      nenable     <= (state_nx == S_DISABLED) || (state_nx == S_ERROR);
      nmute       <= (state_nx == S_PLAY);
      send_config <= (state_nx == S_CONFIG);
    end
  end

endmodule

// File: tb/tb_amp_state_control.sv
// Testbench for amp_state_control: directed vector table, hand-written corner
// sequences and randomized stimulus against a phase/elapsed-time model.
// Honours AMP_ERR_LATCH_EN for the expected post-error behaviour.
module tb_amp_state_control;

  localparam int unsigned P_PWR = 20;
  localparam int unsigned P_CFG = 10;
  localparam int unsigned P_UNM = 8;
  localparam int unsigned P_ERR = 15;

  logic clk;
  logic reset;
  logic audio_locked;
  logic nerror;
  logic nenable;
  logic nmute;
  logic send_config;

  int n_tests = 0;
  int n_fail  = 0;

  amp_state_control #(
    .PWRUP_CYC (P_PWR),
    .CFG_CYC   (P_CFG),
    .UNMUTE_CYC(P_UNM),
    .ERR_CYC   (P_ERR),
    .CNT_W     (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .audio_locked(audio_locked),
    .nerror      (nerror),
    .nenable     (nenable),
    .nmute       (nmute),
    .send_config (send_config)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: current phase plus cycles spent (or lock streak) in it
  typedef enum int {M_DIS, M_ENA, M_CFG, M_CFGW, M_MUTED, M_PLAY, M_ERR} phase_t;
  phase_t      m_ph;
  int unsigned m_t;
  logic [1:0]  m_lk;
  logic [1:0]  m_ne;

  task automatic model_reset();
    m_ph = M_DIS;
    m_t  = 0;
    m_lk = 2'b00;
    m_ne = 2'b11;
  endtask

  task automatic model_step();
    logic lk, er;
    lk = m_lk[1];
    er = ~m_ne[1];
    m_lk = {m_lk[0], audio_locked};
    m_ne = {m_ne[0], nerror};
    if (er && m_ph != M_DIS && m_ph != M_ERR) begin
      m_ph = M_ERR;
      m_t  = 0;
    end else begin
      case (m_ph)
        M_DIS: begin m_ph = M_ENA; m_t = 0; end
        M_ENA: begin
          m_t++;
          if (m_t == P_PWR) m_ph = M_CFG;
        end
        M_CFG: begin m_ph = M_CFGW; m_t = 0; end
        M_CFGW: begin
          m_t++;
          if (m_t == P_CFG) begin m_ph = M_MUTED; m_t = 0; end
        end
        M_MUTED: begin
          if (!lk) m_t = 0;
          else begin
            m_t++;
            if (m_t == P_UNM) m_ph = M_PLAY;
          end
        end
        M_PLAY: if (!lk) begin m_ph = M_MUTED; m_t = 0; end
        M_ERR: begin
`ifndef AMP_ERR_LATCH_EN
          m_t++;
          if (m_t == P_ERR) m_ph = M_DIS;
`endif
        end
        default: m_ph = M_DIS;
      endcase
    end
  endtask

  function automatic int model_exp();
    logic ne, nm, sc;
    ne = (m_ph == M_DIS) || (m_ph == M_ERR);
    nm = (m_ph == M_PLAY);
    sc = (m_ph == M_CFG);
    return int'({ne, nm, sc});
  endfunction

  function automatic int outs();
    return int'({nenable, nmute, send_config});
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Advance n clock edges, stepping the model on each, ending at a negedge
  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      if (reset) model_step();
      @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    reset        = 1'b0;
    audio_locked = 1'b0;
    nerror       = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic        lock;
    logic        nerr;
    int unsigned n;
    int          exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int unsigned cnt;
    bit          found;
    int unsigned err_left;

    // expected value = {nenable, nmute, send_config}
    tbl[0]  = '{1'b0, 1'b1, 1,  3'b000};
    tbl[1]  = '{1'b0, 1'b1, 19, 3'b000};
    tbl[2]  = '{1'b0, 1'b1, 1,  3'b001};
    tbl[3]  = '{1'b0, 1'b1, 1,  3'b000};
    tbl[4]  = '{1'b0, 1'b1, 10, 3'b000};
    tbl[5]  = '{1'b1, 1'b1, 9,  3'b000};
    tbl[6]  = '{1'b1, 1'b1, 1,  3'b010};
    tbl[7]  = '{1'b1, 1'b1, 5,  3'b010};
    tbl[8]  = '{1'b0, 1'b1, 2,  3'b010};
    tbl[9]  = '{1'b0, 1'b1, 1,  3'b000};
    tbl[10] = '{1'b0, 1'b0, 2,  3'b000};
    tbl[11] = '{1'b0, 1'b0, 1,  3'b100};
    tbl[12] = '{1'b0, 1'b1, 14, 3'b100};
    tbl[13] = '{1'b0, 1'b1, 1,  3'b100};
`ifdef AMP_ERR_LATCH_EN
    tbl[14] = '{1'b0, 1'b1, 1,  3'b100};
`else
    tbl[14] = '{1'b0, 1'b1, 1,  3'b000};
`endif

    reset        = 1'b0;
    audio_locked = 1'b0;
    nerror       = 1'b1;
    model_reset();
    @(negedge clk);
    check("reset_state", outs(), 3'b100);
    reset = 1'b1;

    for (int unsigned i = 0; i < 15; i++) begin
      audio_locked = tbl[i].lock;
      nerror       = tbl[i].nerr;
      tick(tbl[i].n);
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Asynchronous reset while waiting on the config transfer
    apply_reset();
    tick(25);
    check("cfg_wait", outs(), 3'b000);
    #2 reset = 1'b0;
    model_reset();
    #1 check("async_reset", outs(), 3'b100);
    @(negedge clk);
    reset = 1'b1;

    // One-cycle lock glitch during qualification restarts the full count
    apply_reset();
    tick(32);
    audio_locked = 1'b1;
    tick(5);
    audio_locked = 1'b0;
    tick(1);
    audio_locked = 1'b1;
    cnt   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < 40 && !found; i++) begin
      tick(1);
      cnt++;
      if (nmute) found = 1'b1;
    end
    check("glitch_unmute_found", int'(found), 1);
    check("glitch_unmute_delay", int'(cnt), 10);

    // Fault in PLAY: enable and mute drop together three edges later
    apply_reset();
    tick(32);
    audio_locked = 1'b1;
    tick(10);
    check("play_before_err", outs(), 3'b010);
    nerror = 1'b0;
    tick(2);
    check("err_sync_delay", outs(), 3'b010);
    tick(1);
    check("err_in_play", outs(), 3'b100);
    tick(2);
    nerror = 1'b1;
`ifdef AMP_ERR_LATCH_EN
    tick(100);
    check("err_latched", outs(), 3'b100);
`else
    found = 1'b0;
    for (int unsigned i = 0; i < 200 && !found; i++) begin
      tick(1);
      if (send_config) found = 1'b1;
    end
    check("restart_config", int'(found), 1);
    found = 1'b0;
    for (int unsigned i = 0; i < 200 && !found; i++) begin
      tick(1);
      if (nmute) found = 1'b1;
    end
    check("restart_unmute", int'(found), 1);
`endif

    // Randomized run against the reference model
    apply_reset();
    err_left = 0;
    for (int unsigned c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b0;
        model_reset();
        #1 check("rand_async_reset", outs(), model_exp());
        @(negedge clk);
        reset = 1'b1;
        continue;
      end
      if (audio_locked) begin
        if ($urandom_range(0, 39) == 0) audio_locked = 1'b0;
      end else begin
        if ($urandom_range(0, 7) == 0) audio_locked = 1'b1;
      end
      if (err_left == 0 && $urandom_range(0, 299) == 0) err_left = $urandom_range(1, 6);
      nerror = (err_left == 0);
      if (err_left > 0) err_left--;
      tick(1);
      check("rand_outputs", outs(), model_exp());
      check("rand_mute_order", int'(nmute & nenable), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
